cpu_state_sequencer: RTL
========================

// Module: cpu_state_sequencer
// PURPOSE
//  Multicycle control FSM for the MIPS core. Generates the one-hot fetch/exec_one/exec_two phase strobes consumed by the IR decoder, register file and ALU.
//  Stretches phases on Avalon waitrequest, inserts fixed-length divide wait states, and halts the core on a jump to address 0.
//  Sits between the top-level bus interface and the decoder/datapath.
// PARAMETERS
//  DIV_CYCLES   default 32   number of DIV_WAIT cycles inserted after EXEC1 for DIV/DIVU (legal 1..255)
//  COUNT_WIDTH  default 32   width of the performance counters (used only with CPU_SEQ_PERF_COUNT_EN)
// PORTS
//  clk            in   1            core clock; all state changes on rising edge
//  reset_n        in   1            asynchronous, active-low reset
//  waitrequest    in   1            Avalon waitrequest from memory bus
//  mem_access     in   1            decoded instr performs a load/store in EXEC2 (valid in EXEC1/EXEC2)
//  is_div         in   1            decoded instr is DIV/DIVU (sampled in EXEC1)
//  halt_req       in   1            next PC == 0x00000000 (sampled in EXEC2)
//  fetch          out  1            FETCH phase strobe
//  exec_one       out  1            EXEC1 phase strobe
//  exec_two       out  1            EXEC2 phase strobe
//  div_busy       out  1            high in DIV_WAIT
//  ir_load        out  1            fetch & ~waitrequest: instruction register capture enable
//  pc_update      out  1            single-cycle pulse on the EXEC2 exit edge to FETCH
//  active         out  1            low only in HALTED
//  state          out  3            encoded state, for debug
//  instr_retired  out  COUNT_WIDTH  retired instruction count
//  stall_cycles   out  COUNT_WIDTH  waitrequest stall cycle count
// BEHAVIOUR
//  States (state encoding): FETCH=3'd0, EXEC1=3'd1, DIV_WAIT=3'd2, EXEC2=3'd3, HALTED=3'd4; codes 5-7 recover to FETCH on the next edge.
//  Reset (asynchronous, any cycle, including mid-DIV_WAIT or mid-stall):
//   - state=FETCH, div counter=0, counters=0.
//   - Outputs fetch=1, active=1; all other strobes=0.
//  FETCH:    waitrequest=1 -> hold FETCH. waitrequest=0 -> ir_load=1 this cycle; next state EXEC1.
//  EXEC1:    always exactly 1 cycle. is_div=1 -> DIV_WAIT with counter cleared; else -> EXEC2.
//  DIV_WAIT: counter increments each cycle; at counter==DIV_CYCLES-1 -> EXEC2 (exactly DIV_CYCLES cycles in this state). waitrequest ignored here.
//  EXEC2:
//   - mem_access & waitrequest -> hold EXEC2; waitrequest takes priority over halt_req.
//   - Otherwise halt_req=1 -> HALTED.
//   - Otherwise -> FETCH, with pc_update=1 in this final EXEC2 cycle.
//  HALTED:   absorbing; all strobes=0, active=0; left only by reset.
//  Strobes: fetch/exec_one/exec_two are Moore outputs (decoded from state only), mutually exclusive, and all 0 in DIV_WAIT and HALTED.
//  ir_load and pc_update are Mealy outputs.
//  Latency: minimum instruction = 3 cycles (FETCH, EXEC1, EXEC2). DIV adds DIV_CYCLES. Each waitrequest cycle adds 1.
// CONFIGURATION
//  CPU_SEQ_PERF_COUNT_EN defined:
//   - instr_retired increments on each EXEC2->FETCH and EXEC2->HALTED transition.
//   - stall_cycles increments on each cycle held in FETCH or EXEC2 by waitrequest.
//   - Both counters wrap modulo 2^COUNT_WIDTH.
//  Not defined: counter registers are not synthesised; instr_retired and stall_cycles are tied to 0. Ports are present in both builds.
// TESTING
//  1. Reset release, waitrequest=0, non-div ALU instrs:
//     - strobe sequence repeats fetch->exec_one->exec_two every 3 cycles.
//     - ir_load and pc_update pulse once per instruction.
//  2. waitrequest=1 for 4 cycles in FETCH:
//     - fetch held 5 cycles; ir_load only in the last one.
//     - stall_cycles=4 (with PERF_EN).
//  3. is_div=1 in EXEC1, DIV_CYCLES=32:
//     - div_busy high exactly 32 cycles; exec_two follows on cycle 34 after EXEC1.
//  4. EXEC2 with mem_access=1, waitrequest=1, halt_req=1 for 2 cycles, then waitrequest=0:
//     - exec_two held 3 cycles, then HALTED; active=0.
//     - pc_update never asserted; stays halted for 100 cycles.
//  5. reset_n pulsed low mid-DIV_WAIT (counter=10):
//     - state=FETCH immediately (asynchronous); after release the next div waits the full 32 cycles.
//  6. PERF_EN, instr_retired preloaded to 2^32-1 via force, one instruction retires -> instr_retired=0.
//     Without the macro, both counters read 0 throughout.

Source files
------------

// File: rtl/cpu_state_sequencer_if.sv
// Bundles the sequencer's bus/decoder handshake inputs and its phase strobes,
// debug state and performance counter outputs.
interface cpu_state_sequencer_if #(
    parameter int COUNT_WIDTH = 32
);
    logic                   waitrequest;
    logic                   mem_access;
    logic                   is_div;
    logic                   halt_req;
    logic                   fetch;
    logic                   exec_one;
    logic                   exec_two;
    logic                   div_busy;
    logic                   ir_load;
    logic                   pc_update;
    logic                   active;
    logic [2:0]             state;
    logic [COUNT_WIDTH-1:0] instr_retired;
    logic [COUNT_WIDTH-1:0] stall_cycles;

    // The sequencer drives the strobes and counters.
    modport master (
        input  waitrequest, mem_access, is_div, halt_req,
        output fetch, exec_one, exec_two, div_busy, ir_load, pc_update,
               active, state, instr_retired, stall_cycles
    );

    modport slave (
        output waitrequest, mem_access, is_div, halt_req,
        input  fetch, exec_one, exec_two, div_busy, ir_load, pc_update,
               active, state, instr_retired, stall_cycles
    );
endinterface

// File: rtl/cpu_state_sequencer.sv
// Multicycle FETCH/EXEC1/DIV_WAIT/EXEC2/HALTED control FSM for the MIPS core.
// Define CPU_SEQ_PERF_COUNT_EN to build the retired/stall performance counters.
module cpu_state_sequencer #(
    parameter int DIV_CYCLES  = 32,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    cpu_state_sequencer_if.master bus
);

    localparam logic [2:0] ST_FETCH    = 3'd0;
    localparam logic [2:0] ST_EXEC1    = 3'd1;
    localparam logic [2:0] ST_DIV_WAIT = 3'd2;
    localparam logic [2:0] ST_EXEC2    = 3'd3;
    localparam logic [2:0] ST_HALTED   = 3'd4;

    localparam logic [7:0] DIV_LAST = 8'(DIV_CYCLES - 1);

    logic [2:0] state_q, state_d;
    logic [7:0] divCount_q, divCount_d;
    logic       exec2Stall;
    logic       exec2Leave;

    assign exec2Stall = (state_q == ST_EXEC2) && bus.mem_access && bus.waitrequest;
    assign exec2Leave = (state_q == ST_EXEC2) && !exec2Stall;

    always_comb begin
        state_d    = state_q;
        divCount_d = divCount_q;
        case (state_q)
            ST_FETCH: begin
                if (!bus.waitrequest) state_d = ST_EXEC1;
            end
            ST_EXEC1: begin
                if (bus.is_div) begin
                    state_d    = ST_DIV_WAIT;
                    divCount_d = 8'd0;
                end else begin
                    state_d = ST_EXEC2;
                end
            end
            ST_DIV_WAIT: begin
                if (divCount_q == DIV_LAST) state_d = ST_EXEC2;
                else                        divCount_d = divCount_q + 8'd1;
            end
            ST_EXEC2: begin
                // A stalled memory access outranks a halt request.
                if (!exec2Stall) state_d = bus.halt_req ? ST_HALTED : ST_FETCH;
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_FETCH;
            divCount_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            divCount_q <= divCount_d;
        end
    end

    assign bus.fetch     = (state_q == ST_FETCH);
    assign bus.exec_one  = (state_q == ST_EXEC1);
    assign bus.exec_two  = (state_q == ST_EXEC2);
    assign bus.div_busy  = (state_q == ST_DIV_WAIT);
    assign bus.active    = (state_q != ST_HALTED);
    assign bus.state     = state_q;
    // Held low while reset is asserted so no capture happens during reset.
    assign bus.ir_load   = bus.fetch && !bus.waitrequest && reset_n;
    assign bus.pc_update = exec2Leave && !bus.halt_req;

`ifdef CPU_SEQ_PERF_COUNT_EN
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    logic [COUNT_WIDTH-1:0] instrRetired_q;
    logic [COUNT_WIDTH-1:0] stallCycles_q;
    logic                   stallNow;

    assign stallNow = (bus.fetch && bus.waitrequest) || exec2Stall;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instrRetired_q <= '0;
            stallCycles_q  <= '0;
        end else begin
            if (exec2Leave) instrRetired_q <= instrRetired_q + CNT_ONE;
            if (stallNow)   stallCycles_q  <= stallCycles_q + CNT_ONE;
        end
    end

    assign bus.instr_retired = instrRetired_q;
    assign bus.stall_cycles  = stallCycles_q;
`else
    assign bus.instr_retired = {COUNT_WIDTH{1'b0}};
    assign bus.stall_cycles  = {COUNT_WIDTH{1'b0}};
`endif

    strobesExclusive: assert property (@(posedge clk) disable iff (!reset_n)
        $onehot0({bus.fetch, bus.exec_one, bus.exec_two, bus.div_busy}));

    haltedAbsorbing: assert property (@(posedge clk) disable iff (!reset_n)
        (state_q == ST_HALTED) |=> (state_q == ST_HALTED));

endmodule
